// File: rtl/bus_pkg.sv
// Shared tick-slot boundaries, Pi FSM state encoding and output bundle for bus_arbiter.
package bus_pkg;

  localparam int unsigned TICK_W = 4;

  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(15);
  localparam logic [TICK_W-1:0] PI_FIRST     = TICK_W'(0);
  localparam logic [TICK_W-1:0] PI_LAST      = TICK_W'(3);
  localparam logic [TICK_W-1:0] PI_STB_FIRST = TICK_W'(1);
  localparam logic [TICK_W-1:0] PI_STB_LAST  = TICK_W'(2);
  localparam logic [TICK_W-1:0] VID_FIRST    = TICK_W'(4);
  localparam logic [TICK_W-1:0] VID_LAST     = TICK_W'(7);
  localparam logic [TICK_W-1:0] VRAM_TICK    = TICK_W'(5);
  localparam logic [TICK_W-1:0] VROM_TICK    = TICK_W'(7);
  localparam logic [TICK_W-1:0] CPU_FIRST    = TICK_W'(8);
  localparam logic [TICK_W-1:0] PHI2_FIRST   = TICK_W'(10);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } pi_state_e;

  typedef struct packed {
    logic clk8;
    logic pi_select;
    logic pi_read;
    logic pi_write;
    logic pi_done;
    logic video_select;
    logic video_ram_strobe;
    logic video_rom_strobe;
    logic cpu_select;
    logic phi2;
  } bus_out_t;

  localparam bus_out_t OUT_RESET = '{clk8: 1'b1, default: 1'b0};

  function automatic logic tick_in(input logic [TICK_W-1:0] t,
                                   input logic [TICK_W-1:0] lo,
                                   input logic [TICK_W-1:0] hi);
    return (t >= lo) && (t <= hi);
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a level crossing into the clk16 domain.
module sync_ff2 (
  input  logic clk16,
  input  logic res_b,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bus_arbiter.sv
// 16-tick bus cycle arbiter: fixed Pi / video / CPU slots plus a Pi request handshake FSM.
// Every port is a flop loaded from the decode of the next tick and next FSM state.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic clk16,
  input  logic res_b,
  input  logic pi_pending,
  input  logic pi_rw_b,
  output logic clk8,
  output logic pi_select,
  output logic pi_read,
  output logic pi_write,
  output logic pi_done,
  output logic video_select,
  output logic video_ram_strobe,
  output logic video_rom_strobe,
  output logic cpu_select,
  output logic phi2
);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              run_q, run_d;
  pi_state_e         state_q, state_d;
  logic              rw_q, rw_d;
  bus_out_t          out_q, out_d;
  logic              pend_s;
  logic              strobe_slot;

  sync_ff2 u_sync (
    .clk16 (clk16),
    .res_b (res_b),
    .d     (pi_pending),
    .q     (pend_s)
  );

  // First edge after reset presents tick 0; counting starts on the next one.
  always_comb begin
    run_d  = 1'b1;
    tick_d = run_q ? tick_q + TICK_W'(1) : '0;
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE:    if (pend_s) state_d = (tick_q == TICK_LAST) ? ACCESS : ARMED;
      ARMED:   if (!pend_s) state_d = IDLE;
               else if (tick_q == TICK_LAST) state_d = ACCESS;
      ACCESS:  if (tick_q == PI_LAST) state_d = DONE;
      DONE:    if (!pend_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Direction is captured once, as the access slot begins.
    if ((state_d == ACCESS) && (state_q != ACCESS)) rw_d = pi_rw_b;
  end

  always_comb begin
    out_d                  = '0;
    strobe_slot            = (state_d == ACCESS) && tick_in(tick_d, PI_STB_FIRST, PI_STB_LAST);
    out_d.clk8             = ~tick_d[0];
    out_d.pi_select        = tick_in(tick_d, PI_FIRST, PI_LAST);
    out_d.pi_read          = strobe_slot & rw_d;
    out_d.pi_write         = strobe_slot & ~rw_d;
    out_d.pi_done          = (state_d == DONE);
    out_d.video_select     = tick_in(tick_d, VID_FIRST, VID_LAST);
    out_d.video_ram_strobe = (tick_d == VRAM_TICK);
    out_d.video_rom_strobe = (tick_d == VROM_TICK);
    out_d.cpu_select       = (tick_d >= CPU_FIRST);
    out_d.phi2             = (tick_d >= PHI2_FIRST);
  end

  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      tick_q  <= '0;
      run_q   <= 1'b0;
      state_q <= IDLE;
      rw_q    <= 1'b1;
      out_q   <= OUT_RESET;
    end else begin
      tick_q  <= tick_d;
      run_q   <= run_d;
      state_q <= state_d;
      rw_q    <= rw_d;
      out_q   <= out_d;
    end
  end

  assign clk8             = out_q.clk8;
  assign pi_select        = out_q.pi_select;
  assign pi_read          = out_q.pi_read;
  assign pi_write         = out_q.pi_write;
  assign pi_done          = out_q.pi_done;
  assign video_select     = out_q.video_select;
  assign video_ram_strobe = out_q.video_ram_strobe;
  assign video_rom_strobe = out_q.video_rom_strobe;
  assign cpu_select       = out_q.cpu_select;
  assign phi2             = out_q.phi2;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed Pi requests push expected strobe/done edges,
// a single monitor process checks slot outputs every cycle and pops edge events.
module tb_bus_arbiter;

  logic clk16      = 1'b0;
  logic res_b      = 1'b0;
  logic pi_pending = 1'b0;
  logic pi_rw_b    = 1'b1;
  logic clk8, pi_select, pi_read, pi_write, pi_done;
  logic video_select, video_ram_strobe, video_rom_strobe, cpu_select, phi2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          fin_req = 1'b0;

  typedef enum int {RD_RISE, RD_FALL, WR_RISE, WR_FALL, DONE_RISE, DONE_FALL} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       tick;
  } ev_t;
  ev_t exp_q[$];

  bus_arbiter dut (
    .clk16            (clk16),
    .res_b            (res_b),
    .pi_pending       (pi_pending),
    .pi_rw_b          (pi_rw_b),
    .clk8             (clk8),
    .pi_select        (pi_select),
    .pi_read          (pi_read),
    .pi_write         (pi_write),
    .pi_done          (pi_done),
    .video_select     (video_select),
    .video_ram_strobe (video_ram_strobe),
    .video_rom_strobe (video_rom_strobe),
    .cpu_select       (cpu_select),
    .phi2             (phi2)
  );

  always #10 clk16 = ~clk16;

  // Reference tick: held at 0 in reset, shows 0 after the first edge, then counts.
  logic [3:0] tb_tick;
  logic       tb_run;
  always @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      tb_tick <= 4'd0;
      tb_run  <= 1'b0;
    end else if (!tb_run) begin
      tb_run <= 1'b1;
    end else begin
      tb_tick <= tb_tick + 4'd1;
    end
  end

  // Expected {clk8, pi_sel, vid_sel, vram, vrom, cpu_sel, phi2} by tick.
  function automatic logic [6:0] slot_vec(input logic [3:0] t, input logic run);
    logic [6:0] v;
    if (!run) return 7'b1000000;
    case (t)
      4'd0:  v = 7'b1100000;
      4'd1:  v = 7'b0100000;
      4'd2:  v = 7'b1100000;
      4'd3:  v = 7'b0100000;
      4'd4:  v = 7'b1010000;
      4'd5:  v = 7'b0011000;
      4'd6:  v = 7'b1010000;
      4'd7:  v = 7'b0010100;
      4'd8:  v = 7'b1000010;
      4'd9:  v = 7'b0000010;
      4'd10: v = 7'b1000011;
      4'd11: v = 7'b0000011;
      4'd12: v = 7'b1000011;
      4'd13: v = 7'b0000011;
      4'd14: v = 7'b1000011;
      default: v = 7'b0000011;
    endcase
    return v;
  endfunction

  task automatic expect_ev(input ev_kind_e k, input int t);
    ev_t e;
    e.kind = k;
    e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at tick %0d, required none", k.name(), tb_tick);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.tick != int'(tb_tick))) begin
        errors++;
        $display("FAIL event: got %s at tick %0d, required %s at tick %0d",
                 k.name(), tb_tick, e.kind.name(), e.tick);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each falling clock or reset assertion.
  logic p_rd = 1'b0, p_wr = 1'b0, p_dn = 1'b0;
  always begin : mon
    logic [6:0] act;
    logic [6:0] expv;
    logic       stb_ok;
    @(negedge clk16 or negedge res_b);
    #1;
    act  = {clk8, pi_select, video_select, video_ram_strobe, video_rom_strobe, cpu_select, phi2};
    expv = slot_vec(tb_tick, tb_run);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL slots: tick=%0d run=%0b got=%b required=%b", tb_tick, tb_run, act, expv);
    end
    stb_ok = !(pi_read && pi_write) &&
             (!(pi_read || pi_write) || (tb_run && (tb_tick == 4'd1 || tb_tick == 4'd2)));
    checks++;
    if (!stb_ok) begin
      errors++;
      $display("FAIL strobe_window: tick=%0d run=%0b got rd=%0b wr=%0b", tb_tick, tb_run,
               pi_read, pi_write);
    end
    if (pi_read  && !p_rd) check_ev(RD_RISE);
    if (!pi_read &&  p_rd) check_ev(RD_FALL);
    if (pi_write && !p_wr) check_ev(WR_RISE);
    if (!pi_write && p_wr) check_ev(WR_FALL);
    if (pi_done  && !p_dn) check_ev(DONE_RISE);
    if (!pi_done &&  p_dn) check_ev(DONE_FALL);
    p_rd = pi_read;
    p_wr = pi_write;
    p_dn = pi_done;
    if (fin_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Wait for the next clock edge that brings the reference tick to t.
  task automatic wait_tick(input int t);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk16);
      #1;
      if (int'(tb_tick) == t) break;
    end
  endtask

  initial begin
    res_b      = 1'b0;
    pi_pending = 1'b0;
    pi_rw_b    = 1'b1;
    repeat (3) @(posedge clk16);
    #1 res_b = 1'b1;
    repeat (64) @(posedge clk16);

    // Read request at tick 6, serviced next cycle; drop after done.
    wait_tick(6);
    pi_rw_b    = 1'b1;
    pi_pending = 1'b1;
    expect_ev(RD_RISE, 1);
    expect_ev(RD_FALL, 3);
    expect_ev(DONE_RISE, 4);
    wait_tick(4);
    pi_pending = 1'b0;
    expect_ev(DONE_FALL, 7);
    wait_tick(12);

    // Synchronized request lands in IDLE at tick 15: write in the very next slot.
    wait_tick(13);
    pi_rw_b    = 1'b0;
    pi_pending = 1'b1;
    expect_ev(WR_RISE, 1);
    expect_ev(WR_FALL, 3);
    expect_ev(DONE_RISE, 4);
    wait_tick(5);
    pi_pending = 1'b0;
    pi_rw_b    = 1'b1;
    expect_ev(DONE_FALL, 8);

    // Three-clock glitch: arms then aborts, nothing expected.
    wait_tick(8);
    pi_pending = 1'b1;
    wait_tick(11);
    pi_pending = 1'b0;
    repeat (40) @(posedge clk16);

    // Direction flips mid-access and request drops at tick 2.
    wait_tick(6);
    pi_rw_b    = 1'b1;
    pi_pending = 1'b1;
    expect_ev(RD_RISE, 1);
    expect_ev(RD_FALL, 3);
    expect_ev(DONE_RISE, 4);
    expect_ev(DONE_FALL, 5);
    wait_tick(1);
    pi_rw_b = 1'b0;
    wait_tick(2);
    pi_pending = 1'b0;
    wait_tick(6);
    pi_rw_b = 1'b1;

    // Reset in the middle of a read strobe.
    wait_tick(6);
    pi_pending = 1'b1;
    expect_ev(RD_RISE, 1);
    expect_ev(RD_FALL, 0);
    wait_tick(1);
    @(negedge clk16);
    #2 res_b = 1'b0;
    pi_pending = 1'b0;
    repeat (3) @(posedge clk16);
    #1 res_b = 1'b1;
    repeat (40) @(posedge clk16);
    fin_req = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have port: clk16  input  1  16 MHz master clock; all state updates on its rising edge.
REQ-002 SHALL have port: res_b  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pi_pending  input  1  Pi access request level, asynchronous to clk16.
REQ-004 SHALL have port: pi_rw_b  input  1  Pi direction: 1 = read, 0 = write.
REQ-005 SHALL have port: clk8  output  1  8 MHz pixel clock, equal to the inverse of tick[0].
REQ-006 SHALL have port: pi_select  output  1  Pi owns bus_addr and ram_addr.
REQ-007 SHALL have port: pi_read / pi_write  output  1 each  Pi strobe qualified by the latched pi_rw_b.
REQ-008 SHALL have port: pi_done  output  1  Pi access complete, four-phase acknowledge.
REQ-009 SHALL have port: video_select, video_ram_strobe, video_rom_strobe  output  1 each  video fetch slot and strobes.
REQ-010 SHALL have port: cpu_select  output  1  CPU slot, drives cpu_be upstream.
REQ-011 SHALL have port: phi2  output  1  1 MHz CPU clock.

Function
REQ-012 SHALL keep a 4-bit free-running tick counter that wraps 15->0, giving one 1 MHz bus cycle per 16 clk16 periods.
REQ-013 SHALL drive every output from a flop, with no combinational decode reaching a port; each value stated for tick t holds while the counter equals t.
REQ-014 SHALL allocate slots as follows: pi_select = ticks 0-3; video_select = ticks 4-7; cpu_select = ticks 8-15.
REQ-015 SHALL assert video_ram_strobe at tick 5 only, and video_rom_strobe at tick 7 only, in every bus cycle.
REQ-016 SHALL assert phi2 at ticks 10-15 only, giving a high phase of 375 ns.
REQ-017 SHALL pass pi_pending through a 2-flop synchronizer; the synchronizer output is pend_s.
REQ-018 SHALL implement the Pi FSM with states IDLE, ARMED, ACCESS and DONE.
REQ-019 SHALL transition IDLE->ARMED when pend_s=1 and tick!=15.
REQ-020 SHALL transition IDLE->ACCESS directly when pend_s=1 and tick==15.
REQ-021 SHALL transition ARMED->ACCESS on the 15->0 wrap when pend_s=1.
REQ-022 SHALL transition ARMED->IDLE when pend_s=0, as an abort with no strobe.
REQ-023 SHALL transition ACCESS->DONE at the end of tick 3, with no exception.
REQ-024 SHALL transition DONE->IDLE when pend_s=0.
REQ-025 SHALL sample pi_rw_b only on entry to ACCESS and hold it through ACCESS; changes to pi_rw_b during ACCESS are ignored.
REQ-026 SHALL assert pi_read or pi_write (per latched rw) at ticks 1-2 only, and only while in ACCESS.
REQ-027 SHALL never start a strobe mid-slot.
REQ-028 SHALL complete an access once in ACCESS, even if pend_s falls; it then passes through DONE for 1 clk, because pend_s=0.
REQ-029 SHALL assert pi_done only in DONE; pi_done SHALL rise at tick 4 of the serviced cycle.
REQ-030 SHALL not accept a new request while in DONE.
REQ-031 SHALL keep pi_select asserted at ticks 0-3 regardless of FSM state, so the slot is always reserved.
REQ-032 SHALL have a worst-case pi_pending-rise to pi_done latency of 2 (sync) + 16 + 4 = 22 clk16.
REQ-033 SHALL never assert more than one of pi_select, video_select and cpu_select at a time.

Reset
REQ-034 SHALL, while res_b=0, hold tick=0 and FSM=IDLE, with synchronizer flops and the latched rw at 0/1 respectively.
REQ-035 SHALL, while res_b=0, hold all outputs low except clk8=1.
REQ-036 SHALL start at tick 0 on the first rising clk16 after res_b deasserts; reset mid-access SHALL abort with no further strobe.

Structure
REQ-037 SHALL take the tick boundary constants (PI_FIRST/LAST, VID_FIRST/LAST, VRAM_TICK, VROM_TICK, CPU_FIRST, PHI2_FIRST) and the FSM state enum from shared package bus_pkg.
REQ-038 SHALL instantiate the synchronizer as sub-module sync_ff2 (clk16, res_b, d, q).

Verification
REQ-039 Reset release, 64 clk16, no request -> phi2 high exactly ticks 10-15, video_ram_strobe at 5, video_rom_strobe at 7, pi_read/pi_write never high.
REQ-040 pi_pending rises at tick 6, pi_rw_b=1 -> pi_read high ticks 1-2 of next cycle, pi_done rises at tick 4; drop pi_pending -> pi_done low 2-3 clk later.
REQ-041 Synchronized request arrives in IDLE at tick 15, pi_rw_b=0 -> ACCESS at tick 0, pi_write at ticks 1-2 of that same cycle.
REQ-042 pi_pending pulses for 3 clk during ticks 8-11 -> ARMED then IDLE, no strobe, pi_done stays 0.
REQ-043 pi_rw_b toggles during tick 1 of ACCESS -> strobe type unchanged; pi_pending dropped at tick 2 -> strobe completes and pi_done pulses 1 clk.
REQ-044 res_b asserted at tick 1 of ACCESS -> all outputs low (clk8=1) immediately; after release, tick restarts at 0 in IDLE.
